// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259A host-bus initiator.
// Holds command/state encodings, ICW1 bit positions, OCW discriminators and per-word A0 values.
package pic_bus_pkg;

  typedef enum logic [2:0] {
    OP_INIT = 3'd0,
    OP_OCW1 = 3'd1,
    OP_OCW2 = 3'd2,
    OP_OCW3 = 3'd3,
    OP_READ = 3'd4
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER,
    ST_NEXT
  } bus_state_e;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ID   = 4;

  // Bits [4:3] tell the PIC which OCW (or ICW1) it is looking at.
  localparam int         OCW_SEL_LSB = 3;
  localparam int         OCW_SEL_MSB = 4;
  localparam logic [1:0] OCW2_SEL    = 2'b00;
  localparam logic [1:0] OCW3_SEL    = 2'b01;

  localparam logic A0_ICW1 = 1'b0;
  localparam logic A0_ICW2 = 1'b1;
  localparam logic A0_ICW3 = 1'b1;
  localparam logic A0_ICW4 = 1'b1;
  localparam logic A0_OCW1 = 1'b1;
  localparam logic A0_OCW2 = 1'b0;
  localparam logic A0_OCW3 = 1'b0;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'(OP_READ);
  endfunction

endpackage

// File: rtl/pic_bus_pic_bus_cycle.sv
// Single timed 8259A bus cycle: SETUP -> STROBE -> HOLD -> RECOVER, driven by a 4-bit down-counter.
// A start seen on the last RECOVER cycle chains straight into the next SETUP.
//
// state   | meaning
// IDLE    | bus released, waiting for start
// SETUP   | CS low, A0/data valid, strobes high
// STROBE  | WR or RD low
// HOLD    | strobe back high, CS/A0/data still held
// RECOVER | CS high between cycles
// NEXT    | zero-cycle hand-off, taken as RECOVER -> SETUP when start is present
module pic_bus_cycle
  import pic_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WR_PULSE     = 2,
  parameter int unsigned RD_PULSE     = 2,
  parameter int unsigned RECOVERY     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       is_read,
  input  logic       a0,
  input  logic [7:0] wdata,
  input  logic [7:0] bus_in,
  output logic       idle,
  output logic       cycle_done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0_out,
  output logic [7:0] dout,
  output logic       oe,
  output logic [7:0] rdata
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || WR_PULSE < 1 || WR_PULSE > 15 ||
      RD_PULSE < 1 || RD_PULSE > 15 || RECOVERY < 1 || RECOVERY > 15) begin : g_bad_param
    $error("pic_bus_cycle: timing parameters must lie in 1..15");
  end

  localparam logic [3:0] CNT_SETUP = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] CNT_WR    = 4'(WR_PULSE - 1);
  localparam logic [3:0] CNT_RD    = 4'(RD_PULSE - 1);
  localparam logic [3:0] CNT_REC   = 4'(RECOVERY - 1);

  bus_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_read_q, is_read_d;
  logic       a0_q, a0_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       load;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_read_q <= 1'b0;
      a0_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      a0_q      <= a0_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_read_d  = is_read_q;
    a0_d       = a0_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cycle_done = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) load = 1'b1;
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = is_read_q ? CNT_RD : CNT_WR;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Read data is taken on the last RD-low cycle, just before RD rises.
          if (is_read_q) rdata_d = bus_in;
          state_d = ST_HOLD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_RECOVER;
        cnt_d   = CNT_REC;
      end
      ST_RECOVER: begin
        if (cnt_q == 4'd0) begin
          cycle_done = 1'b1;
          if (start) load = 1'b1;
          else       state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d   = ST_SETUP;
      cnt_d     = CNT_SETUP;
      is_read_d = is_read;
      a0_d      = a0;
      wdata_d   = wdata;
    end
  end

  logic bus_active;
  assign bus_active = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);

  assign idle   = (state_q == ST_IDLE);
  assign cs_n   = ~bus_active;
  assign wr_n   = ~((state_q == ST_STROBE) && !is_read_q);
  assign rd_n   = ~((state_q == ST_STROBE) && is_read_q);
  assign oe     = bus_active && !is_read_q;
  assign a0_out = a0_q;
  assign dout   = wdata_q;
  assign rdata  = rdata_q;

endmodule

// File: rtl/pic_bus_master.sv
// CPU-side 8259A bus initiator: captures host commands, forces ICW/OCW discriminator bits
// and sequences the INIT words through the single-cycle bus engine.
module pic_bus_master
  import pic_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WR_PULSE     = 2,
  parameter int unsigned RD_PULSE     = 2,
  parameter int unsigned RECOVERY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        CS,
  output logic        WR,
  output logic        RD,
  output logic        address,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_oe,
  input  logic [7:0]  data_bus_in,
  output logic [7:0]  rsp_data,
  output logic        done,
  output logic        cmd_error
);

  cmd_op_e     op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  word_q, word_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        cyc_idle, cyc_done, cyc_start;
  logic        accept;
  cmd_op_e     sel_op;
  logic [31:0] sel_data;
  logic [1:0]  sel_word;
  logic        w_read, w_a0;
  logic [7:0]  w_data;
  logic        more;
  logic [1:0]  nxt;

  assign cmd_ready = cyc_idle;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= OP_INIT;
      data_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      data_q  <= data_d;
      word_q  <= word_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // INIT word order: ICW1, ICW2, then ICW3 unless SNGL, then ICW4 only if IC4.
  always_comb begin
    more = 1'b0;
    nxt  = word_q;
    case (word_q)
      2'd0: begin
        more = 1'b1;
        nxt  = 2'd1;
      end
      2'd1: begin
        if (!data_q[ICW1_SNGL]) begin
          more = 1'b1;
          nxt  = 2'd2;
        end else if (data_q[ICW1_IC4]) begin
          more = 1'b1;
          nxt  = 2'd3;
        end
      end
      2'd2: begin
        if (data_q[ICW1_IC4]) begin
          more = 1'b1;
          nxt  = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    data_d    = data_q;
    word_d    = word_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    cyc_start = 1'b0;
    sel_op    = op_q;
    sel_data  = data_q;
    sel_word  = word_q;

    if (accept) begin
      // The first word is launched on the accept edge, so it comes from the live inputs.
      op_d     = cmd_op_e'(cmd_op);
      data_d   = cmd_data;
      word_d   = 2'd0;
      sel_op   = cmd_op_e'(cmd_op);
      sel_data = cmd_data;
      sel_word = 2'd0;
      if (is_legal_op(cmd_op)) begin
        cyc_start = 1'b1;
      end else begin
        done_d  = 1'b1;
        error_d = 1'b1;
      end
    end else if (cyc_done) begin
      if (op_q == OP_INIT && more) begin
        cyc_start = 1'b1;
        word_d    = nxt;
        sel_word  = nxt;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    w_read = 1'b0;
    w_a0   = 1'b0;
    w_data = '0;
    case (sel_op)
      OP_INIT: begin
        case (sel_word)
          2'd0: begin
            w_data          = sel_data[7:0];
            w_data[ICW1_ID] = 1'b1;
            w_a0            = A0_ICW1;
          end
          2'd1: begin
            w_data = sel_data[15:8];
            w_a0   = A0_ICW2;
          end
          2'd2: begin
            w_data = sel_data[23:16];
            w_a0   = A0_ICW3;
          end
          default: begin
            w_data = sel_data[31:24];
            w_a0   = A0_ICW4;
          end
        endcase
      end
      OP_OCW1: begin
        w_data = sel_data[7:0];
        w_a0   = A0_OCW1;
      end
      OP_OCW2: begin
        w_data                          = sel_data[7:0];
        w_data[OCW_SEL_MSB:OCW_SEL_LSB] = OCW2_SEL;
        w_a0                            = A0_OCW2;
      end
      OP_OCW3: begin
        w_data                          = sel_data[7:0];
        w_data[OCW_SEL_MSB:OCW_SEL_LSB] = OCW3_SEL;
        w_a0                            = A0_OCW3;
      end
      OP_READ: begin
        w_read = 1'b1;
        w_a0   = sel_data[0];
      end
      default: ;
    endcase
  end

  pic_bus_cycle #(
    .SETUP_CYCLES(SETUP_CYCLES),
    .WR_PULSE    (WR_PULSE),
    .RD_PULSE    (RD_PULSE),
    .RECOVERY    (RECOVERY)
  ) u_cycle (
    .clock     (clock),
    .reset     (reset),
    .start     (cyc_start),
    .is_read   (w_read),
    .a0        (w_a0),
    .wdata     (w_data),
    .bus_in    (data_bus_in),
    .idle      (cyc_idle),
    .cycle_done(cyc_done),
    .cs_n      (CS),
    .wr_n      (WR),
    .rd_n      (RD),
    .a0_out    (address),
    .dout      (data_bus_out),
    .oe        (data_bus_oe),
    .rdata     (rsp_data)
  );

  assign done      = done_q;
  assign cmd_error = error_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// Directed bench for pic_bus_master: per-cycle bus-shape checks against a cycle-offset model
// and a scoreboard of expected (A0, data) words pushed when each command is issued.
module tb_pic_bus_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        CS, WR, RD, address;
  logic [7:0]  data_bus_out;
  logic        data_bus_oe;
  logic [7:0]  data_bus_in;
  logic [7:0]  rsp_data;
  logic        done, cmd_error;

  logic [7:0]  pic_rd_val = 8'h5C;
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  sb[$];   // {is_read, a0, data}

  always #5 clock = ~clock;

  // PIC model: drives its register value only while RD is low.
  assign data_bus_in = RD ? 8'hAA : pic_rd_val;

  pic_bus_master dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .CS          (CS),
    .WR          (WR),
    .RD          (RD),
    .address     (address),
    .data_bus_out(data_bus_out),
    .data_bus_oe (data_bus_oe),
    .data_bus_in (data_bus_in),
    .rsp_data    (rsp_data),
    .done        (done),
    .cmd_error   (cmd_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called in the cycle before the intended accept edge.
  task automatic send(input logic [2:0] op, input logic [31:0] d);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd1;
    cmd_data  = ~d;
  endtask

  // Word i occupies cycles 5i+1..5i+5 (SETUP, STROBE x2, HOLD, RECOVER); done at 5n+1.
  task automatic watch(input string tag, input int nwords, input bit is_read,
                       input bit illegal, input int ncyc);
    logic [9:0] e;
    logic [7:0] exp_rsp;
    logic [6:0] exp_v, obs_v;
    int w, off;
    exp_rsp = 8'h00;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      w     = (k - 1) / 5;
      off   = (k - 1) % 5 + 1;
      exp_v = 7'b1110001;   // {CS, WR, RD, oe, done, err, ready}
      if (w < nwords) begin
        exp_v[0] = 1'b0;
        if (off <= 4) exp_v[6] = 1'b0;
        if (off == 2 || off == 3) begin
          if (is_read) exp_v[4] = 1'b0;
          else         exp_v[5] = 1'b0;
        end
        if (!is_read && off <= 4) exp_v[3] = 1'b1;
      end
      if (k == 5 * nwords + 1) begin
        exp_v[2] = 1'b1;
        exp_v[1] = illegal;
      end
      obs_v = {CS, WR, RD, data_bus_oe, done, cmd_error, cmd_ready};
      check($sformatf("%s c%0d bus", tag, k), 32'(obs_v), 32'(exp_v));
      if (w < nwords && off == 1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s c%0d scoreboard observed empty expected entry", tag, k);
        end else begin
          e = sb.pop_front();
          check($sformatf("%s w%0d a0", tag, w), 32'(address), 32'(e[8]));
          if (!e[9]) check($sformatf("%s w%0d data", tag, w), 32'(data_bus_out), 32'(e[7:0]));
          else       exp_rsp = e[7:0];
        end
      end
      if (is_read && k == 5 * nwords + 1)
        check($sformatf("%s rsp", tag), 32'(rsp_data), 32'(exp_rsp));
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    check("reset bus", 32'({CS, WR, RD, data_bus_oe, done, cmd_error, cmd_ready}), 32'(7'b1110001));
    check("reset addr/data", 32'({address, data_bus_out}), 32'h0);
    check("reset rsp", 32'(rsp_data), 32'h0);

    sb.push_back({1'b0, 1'b1, 8'hA5});
    send(3'd1, 32'h0000_00A5);
    watch("ocw1", 1, 1'b0, 1'b0, 7);

    sb.push_back({1'b0, 1'b0, 8'h11});
    sb.push_back({1'b0, 1'b1, 8'h20});
    sb.push_back({1'b0, 1'b1, 8'h04});
    sb.push_back({1'b0, 1'b1, 8'h01});
    send(3'd0, 32'h0104_2011);
    watch("init4", 4, 1'b0, 1'b0, 22);

    sb.push_back({1'b0, 1'b0, 8'h13});
    sb.push_back({1'b0, 1'b1, 8'h20});
    sb.push_back({1'b0, 1'b1, 8'h01});
    send(3'd0, 32'h0104_2003);
    watch("init3", 3, 1'b0, 1'b0, 17);

    sb.push_back({1'b0, 1'b0, 8'h12});
    sb.push_back({1'b0, 1'b1, 8'h34});
    send(3'd0, 32'h5566_3402);
    watch("init2", 2, 1'b0, 1'b0, 12);

    // OCW3 is accepted on the OCW2 done cycle.
    sb.push_back({1'b0, 1'b0, 8'hE7});
    send(3'd2, 32'h0000_00FF);
    watch("ocw2", 1, 1'b0, 1'b0, 6);
    sb.push_back({1'b0, 1'b0, 8'hEF});
    send(3'd3, 32'h0000_00FF);
    watch("ocw3", 1, 1'b0, 1'b0, 7);

    sb.push_back({1'b1, 1'b1, 8'h5C});
    send(3'd4, 32'h0000_0001);
    watch("read1", 1, 1'b1, 1'b0, 7);

    pic_rd_val = 8'h3A;
    sb.push_back({1'b1, 1'b0, 8'h3A});
    send(3'd4, 32'hFFFF_FF00);
    watch("read0", 1, 1'b1, 1'b0, 7);

    send(3'd6, 32'h1234_5678);
    watch("illegal", 0, 1'b0, 1'b1, 3);

    send(3'd0, 32'h0104_2011);
    @(negedge clock);
    check("abort c1 cs", 32'(CS), 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort c3 bus", 32'({CS, WR, RD, data_bus_oe, done, cmd_error, cmd_ready}), 32'(7'b1110001));
    check("abort c3 rsp", 32'(rsp_data), 32'h0);
    for (int k = 4; k <= 8; k++) begin
      @(negedge clock);
      check($sformatf("abort c%0d quiet", k), 32'({CS, done}), 32'(2'b10));
    end

    sb.push_back({1'b0, 1'b1, 8'h5A});
    send(3'd1, 32'h0000_005A);
    watch("ocw1 post", 1, 1'b0, 1'b0, 7);

    check("sb drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_bus_master.md
Name: pic_bus_master

Overview:
CPU-side initiator for the 8259A host bus. It turns single-cycle host commands (init, OCW write, register read) into correctly timed CS/WR/RD/A0/data bus cycles for the PIC's bus control logic. On INIT it runs the full ICW1 -> ICW2 -> [ICW3] -> [ICW4] sequence. It forces the ICW/OCW discriminator bits so that the PIC decodes each word unambiguously.

Parameters:
SETUP_CYCLES, 1, cycles with CS/A0/data valid before the strobe falls (1..15)
WR_PULSE, 2, cycles WR is held low (1..15)
RD_PULSE, 2, cycles RD is held low (1..15)
RECOVERY, 1, cycles CS is held high between consecutive bus cycles (1..15)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready at the clock edge
cmd_op  in  3  0 INIT, 1 OCW1, 2 OCW2, 3 OCW3, 4 READ, 5-7 illegal
cmd_data  in  32  INIT: [7:0] ICW1, [15:8] ICW2, [23:16] ICW3, [31:24] ICW4; OCWx: [7:0]; READ: bit0 = A0
CS  out  1  chip select, active low
WR  out  1  write strobe, active low
RD  out  1  read strobe, active low
address  out  1  A0
data_bus_out  out  8  write data
data_bus_oe  out  1  high while this block drives the data bus
data_bus_in  in  8  read data from PIC
rsp_data  out  8  last read value; held until the next READ completes
done  out  1  one-cycle pulse when a command completes
cmd_error  out  1  one-cycle pulse together with done for an illegal op

Behaviour:
- Reset values: CS=1, WR=1, RD=1, address=0, data_bus_out=0, data_bus_oe=0, rsp_data=0, done=0, cmd_error=0. The FSM enters IDLE, so cmd_ready=1 on the first cycle after reset deasserts.
- Command capture: cmd_op and cmd_data are registered on accept. Later changes on cmd_* have no effect until the next accept.
- Word forcing:
  - ICW1 bit4 is forced to 1.
  - OCW2 bits[4:3] are forced to 00.
  - OCW3 bits[4:3] are forced to 01.
  - ICW2, ICW3, ICW4 and OCW1 pass through unchanged.
- A0 per word: ICW1=0, ICW2=1, ICW3=1, ICW4=1, OCW1=1, OCW2=0, OCW3=0. READ uses cmd_data[0].
- INIT word selection comes from the captured ICW1:
  - ICW3 is sent only if SNGL (bit1) = 0.
  - ICW4 is sent only if IC4 (bit0) = 1.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER, NEXT.
  - SETUP (SETUP_CYCLES cycles): CS=0, address and data valid, WR=RD=1. data_bus_oe=1 for writes, 0 for reads.
  - STROBE: WR=0 for WR_PULSE cycles, or RD=0 for RD_PULSE cycles. For reads, rsp_data samples data_bus_in on the last RD-low cycle.
  - HOLD (1 cycle): WR/RD=1 while CS, address and data are still held. The PIC sees its WR rising edge here.
  - RECOVER (RECOVERY cycles): CS=1, data_bus_oe=0. Then go to NEXT if more INIT words remain, otherwise to IDLE.
  - NEXT: selects the next word in zero cycles, i.e. RECOVER goes directly to SETUP of the next word.
- done timing: done (and rsp_data valid for READ) pulses on the first IDLE cycle after the final RECOVER. cmd_ready is also 1 in that cycle, so back-to-back accept is allowed.
- Latency with defaults: one word occupies 5 cycles (c1 SETUP, c2-c3 STROBE, c4 HOLD, c5 RECOVER); done is at c6. A full 4-word INIT finishes with done at c21.
- Illegal op: no bus activity; done=1 and cmd_error=1 in the cycle after accept, FSM stays in IDLE.
- Reset mid-command: at the next edge all outputs take their reset values and the command is abandoned, with no done. rsp_data is cleared.
- Timing counter: 4-bit down-counter, reloaded on each state entry. Parameters outside 1..15 are a configuration error, caught by an elaboration assertion.

Decomposition:
- Package pic_bus_pkg holds:
  - the cmd_op enum
  - the FSM state enum
  - ICW1 bit positions (IC4=0, SNGL=1, ICW1_ID=4)
  - OCW discriminator constants
  - the per-word A0 constants
- One sub-module, pic_bus_cycle: performs a single timed read or write bus cycle (SETUP/STROBE/HOLD/RECOVER plus the counter) given start, is_read, a0 and wdata, and returns cycle_done and rdata.
- The top level holds the command capture, word forcing and the INIT word sequencer.

Test Plan:
- OCW1, cmd_data=0x000000A5: CS=0 c1-c4; WR=0 c2-c3; address=1; data_bus_out=0xA5 and oe=1 c1-c4; CS=1 at c5; done at c6.
- INIT, cmd_data=0x0104_2011: four writes with (A0,data) = (0,0x11), (1,0x20), (1,0x04), (1,0x01). CS high exactly 1 cycle between words; done at c21.
- INIT, cmd_data=0x0104_2003: ICW3 skipped, three writes (0,0x13), (1,0x20), (1,0x01); done at c16. Then INIT with ICW1=0x02: two writes (0,0x12), (1,ICW2); done at c11.
- OCW2, cmd_data=0xFF: data 0xE7, A0=0. OCW3, cmd_data=0xFF: data 0xEF, A0=0. Issued back-to-back with the second accepted on the first done cycle.
- READ, cmd_data=1, data_bus_in=0x5C during RD-low: RD=0 c2-c3, oe=0 throughout, address=1; rsp_data=0x5C with done at c6. cmd_op=6: done and cmd_error both high at c1, no CS activity.
- INIT accepted, reset asserted at c2 for one cycle: at c3 CS=WR=RD=1, oe=0, no done. An OCW1 accepted after reset completes normally.
